// File: rtl/mem_wb_stage_pkg.sv
// Shared write-back select codes, load funct3 encodings and datapath defaults
// for the MEM/WB stage and its load-alignment helper.
package mem_wb_stage_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 64;

    typedef enum logic [1:0] {
        WBSEL_ALU = 2'b00,
        WBSEL_MEM = 2'b01,
        WBSEL_PC4 = 2'b10,
        WBSEL_IMM = 2'b11
    } wbsel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load extraction: picks the byte/half addressed by the low
// address bits from the aligned memory word and sign/zero-extends it.
module wb_load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Halfword loads ignore addr_lo[0]; misalignment is not trapped here.
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Reserved encodings (011/110/111) fall through to a full-word load.
    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back formation feeding the register file.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_regwrite,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wbsel,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [XLEN-1:0] in_imm,
    output logic            wb_valid,
    output logic            regwrite,
    output logic [4:0]      writereg,
    output logic [XLEN-1:0] writedata
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    logic            r_valid;
    logic            r_regwrite;
    logic [4:0]      r_rd;
    wbsel_e          r_wbsel;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_imm;

    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_data;

    // Flush only needs to kill valid/regwrite; the payload is left as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_wbsel    <= WBSEL_ALU;
            r_funct3   <= '0;
            r_addr_lo  <= '0;
            r_alu      <= '0;
            r_rdata    <= '0;
            r_pc4      <= '0;
            r_imm      <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
        end else if (!stall) begin
            r_valid    <= in_valid;
            r_regwrite <= in_regwrite;
            r_rd       <= in_rd;
            r_wbsel    <= wbsel_e'(in_wbsel);
            r_funct3   <= in_funct3;
            r_addr_lo  <= in_addr_lo;
            r_alu      <= in_alu_result;
            r_rdata    <= in_mem_rdata;
            r_pc4      <= in_pc4;
            r_imm      <= in_imm;
        end
    end

    wb_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .i_rdata  (r_rdata),
        .i_funct3 (r_funct3),
        .i_addr_lo(r_addr_lo),
        .o_data   (w_load)
    );

    always_comb begin
        w_data = r_alu;
        case (r_wbsel)
            WBSEL_ALU: w_data = r_alu;
            WBSEL_MEM: w_data = w_load;
            WBSEL_PC4: w_data = r_pc4;
            WBSEL_IMM: w_data = r_imm;
            default:   w_data = r_alu;
        endcase
    end

    // A stalled instruction keeps regwrite high; rewriting the same value is harmless.
    assign wb_valid  = r_valid;
    assign regwrite  = r_valid & r_regwrite & (r_rd != 5'd0);
    assign writereg  = r_rd;
    assign writedata = w_data;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (r_valid && !stall) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for the write-back mux and load
// extraction, plus hand sequences for reset, stall/flush and WB_RETIRE_CNT_EN.
module tb_mem_wb_stage;

    localparam int XLEN     = 32;
    localparam int TB_CNT_W = 4;
    localparam logic [31:0] RDATA = 32'h80FF_7F01;
    localparam logic [31:0] JUNK  = 32'hDEAD_0000;

    logic            clk = 1'b0;
    logic            rst, stall, flush;
    logic            in_valid, in_regwrite;
    logic [4:0]      in_rd;
    logic [1:0]      in_wbsel;
    logic [2:0]      in_funct3;
    logic [1:0]      in_addr_lo;
    logic [XLEN-1:0] in_alu_result, in_mem_rdata, in_pc4, in_imm;
    logic            wb_valid, regwrite;
    logic [4:0]      writereg;
    logic [XLEN-1:0] writedata;
`ifdef WB_RETIRE_CNT_EN
    logic [TB_CNT_W-1:0] instret;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  wbsel;
        logic [2:0]  funct3;
        logic [1:0]  addrLo;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic        expValid;
        logic        expRw;
        logic [4:0]  expRd;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    mem_wb_stage #(
        .XLEN (XLEN),
        .CNT_W(TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_regwrite  (in_regwrite),
        .in_rd        (in_rd),
        .in_wbsel     (in_wbsel),
        .in_funct3    (in_funct3),
        .in_addr_lo   (in_addr_lo),
        .in_alu_result(in_alu_result),
        .in_mem_rdata (in_mem_rdata),
        .in_pc4       (in_pc4),
        .in_imm       (in_imm),
        .wb_valid     (wb_valid),
        .regwrite     (regwrite),
        .writereg     (writereg),
        .writedata    (writedata)
`ifdef WB_RETIRE_CNT_EN
        ,
        .instret      (instret)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid      = v.valid;
        in_regwrite   = v.rw;
        in_rd         = v.rd;
        in_wbsel      = v.wbsel;
        in_funct3     = v.funct3;
        in_addr_lo    = v.addrLo;
        in_alu_result = v.alu;
        in_mem_rdata  = v.rdata;
        in_pc4        = v.pc4;
        in_imm        = v.imm;
    endtask

    task automatic setAlu(input logic valid, input logic [4:0] rd, input logic [31:0] value);
        in_valid      = valid;
        in_regwrite   = 1'b1;
        in_rd         = rd;
        in_wbsel      = 2'b00;
        in_funct3     = 3'b010;
        in_addr_lo    = 2'b00;
        in_alu_result = value;
        in_mem_rdata  = 32'h0;
        in_pc4        = 32'h0;
        in_imm        = 32'h0;
    endtask

    task automatic checkWb(input string tag, input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] d);
        checkOutput({tag, " wb_valid"},  64'(wb_valid),  64'(v));
        checkOutput({tag, " regwrite"},  64'(regwrite),  64'(rw));
        checkOutput({tag, " writereg"},  64'(writereg),  64'(rd));
        checkOutput({tag, " writedata"}, 64'(writedata), 64'(d));
    endtask

    initial begin
        vecs[0]  = '{1, 1, 5,  2'b00, 3'b000, 2'd0, 32'h1234, RDATA, 32'h4,   32'h0,        1, 1, 5,  32'h0000_1234};
        vecs[1]  = '{1, 1, 0,  2'b00, 3'b000, 2'd0, 32'h1234, RDATA, 32'h4,   32'h0,        1, 0, 0,  32'h0000_1234};
        vecs[2]  = '{1, 1, 3,  2'b01, 3'b000, 2'd3, JUNK,     RDATA, 32'h0,   32'h0,        1, 1, 3,  32'hFFFF_FF80};
        vecs[3]  = '{1, 1, 3,  2'b01, 3'b100, 2'd1, JUNK,     RDATA, 32'h0,   32'h0,        1, 1, 3,  32'h0000_007F};
        vecs[4]  = '{1, 1, 4,  2'b01, 3'b001, 2'd2, JUNK,     RDATA, 32'h0,   32'h0,        1, 1, 4,  32'hFFFF_80FF};
        vecs[5]  = '{1, 1, 4,  2'b01, 3'b101, 2'd0, JUNK,     RDATA, 32'h0,   32'h0,        1, 1, 4,  32'h0000_7F01};
        vecs[6]  = '{1, 1, 6,  2'b01, 3'b010, 2'd0, JUNK,     RDATA, 32'h0,   32'h0,        1, 1, 6,  32'h80FF_7F01};
        vecs[7]  = '{1, 1, 6,  2'b01, 3'b011, 2'd2, JUNK,     RDATA, 32'h0,   32'h0,        1, 1, 6,  32'h80FF_7F01};
        vecs[8]  = '{1, 1, 10, 2'b01, 3'b001, 2'd3, JUNK,     RDATA, 32'h0,   32'h0,        1, 1, 10, 32'hFFFF_80FF};
        vecs[9]  = '{1, 1, 11, 2'b01, 3'b000, 2'd2, JUNK,     RDATA, 32'h0,   32'h0,        1, 1, 11, 32'hFFFF_FFFF};
        vecs[10] = '{1, 1, 12, 2'b01, 3'b101, 2'd1, JUNK,     RDATA, 32'h0,   32'h0,        1, 1, 12, 32'h0000_7F01};
        vecs[11] = '{1, 1, 1,  2'b10, 3'b000, 2'd0, JUNK,     RDATA, 32'h104, 32'h0,        1, 1, 1,  32'h0000_0104};
        vecs[12] = '{1, 1, 31, 2'b11, 3'b000, 2'd0, JUNK,     RDATA, 32'h104, 32'hABCD_E000, 1, 1, 31, 32'hABCD_E000};
        vecs[13] = '{0, 1, 7,  2'b00, 3'b000, 2'd0, 32'h55,   RDATA, 32'h0,   32'h0,        0, 0, 7,  32'h0000_0055};
        vecs[14] = '{1, 0, 8,  2'b00, 3'b000, 2'd0, 32'h66,   RDATA, 32'h0,   32'h0,        1, 0, 8,  32'h0000_0066};
        vecs[15] = '{1, 1, 9,  2'b01, 3'b000, 2'd0, JUNK,     RDATA, 32'h0,   32'h0,        1, 1, 9,  32'h0000_0001};

        // Reset with a live instruction presented at the inputs.
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        setAlu(1'b1, 5'd5, 32'hCAFE_F00D);
        repeat (2) @(negedge clk);
        checkWb("reset", 1'b0, 1'b0, 5'd0, 32'h0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("reset instret", 64'(instret), 64'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkWb($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expRw, vecs[i].expRd, vecs[i].expData);
        end

        // Stall freezes the prior instruction and keeps re-asserting regwrite.
        setAlu(1'b1, 5'd9, 32'h0000_A5A5);
        @(negedge clk);
        checkWb("stall pre", 1'b1, 1'b1, 5'd9, 32'h0000_A5A5);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            setAlu(1'b1, 5'd20 + 5'(c), 32'h1111_0000 + 32'(c));
            @(negedge clk);
            checkWb($sformatf("stall%0d", c), 1'b1, 1'b1, 5'd9, 32'h0000_A5A5);
        end
        stall = 1'b0;
        setAlu(1'b1, 5'd14, 32'h0000_BEEF);
        @(negedge clk);
        checkWb("stall release", 1'b1, 1'b1, 5'd14, 32'h0000_BEEF);

        // Flush wins over stall.
        stall = 1'b1; flush = 1'b1;
        setAlu(1'b1, 5'd15, 32'h0000_1515);
        @(negedge clk);
        checkOutput("stall+flush wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("stall+flush regwrite", 64'(regwrite), 64'd0);
        stall = 1'b0; flush = 1'b0;
        setAlu(1'b1, 5'd16, 32'h0000_1616);
        @(negedge clk);
        checkWb("post flush", 1'b1, 1'b1, 5'd16, 32'h0000_1616);

        // Reset asserted during a stall empties the stage.
        stall = 1'b1; rst = 1'b1;
        @(negedge clk);
        checkWb("rst mid-stall", 1'b0, 1'b0, 5'd0, 32'h0);
        stall = 1'b0; rst = 1'b0;

`ifdef WB_RETIRE_CNT_EN
        rst = 1'b1;
        setAlu(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // Ten valid instructions with three stalled cycles sprinkled in.
        for (int n = 0; n < 10; n++) begin
            setAlu(1'b1, 5'd1, 32'(n));
            stall = 1'b0;
            @(negedge clk);
            if (n == 2 || n == 5 || n == 7) begin
                stall = 1'b1;
                @(negedge clk);
                stall = 1'b0;
            end
        end
        setAlu(1'b0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("instret ten", 64'(instret), 64'd10);
        for (int n = 0; n < 5; n++) begin
            setAlu(1'b1, 5'd2, 32'(n));
            @(negedge clk);
        end
        setAlu(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("instret all-ones", 64'(instret), 64'd15);
        setAlu(1'b1, 5'd3, 32'h0);
        @(negedge clk);
        setAlu(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("instret wrap", 64'(instret), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
